// File: rtl/debayer_line_ctrl.sv
// debayer_line_ctrl: 4-line ring buffer controller for a debayer stage; writes incoming lines
// into a bank ring and scans a 3-line window out once enough lines are buffered.
module debayer_line_ctrl #(
    parameter int LINE_LENGTH = 640,
    parameter int MIN_LINES = 3,
    localparam int CNT_W = $clog2(LINE_LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             data_valid,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [CNT_W-1:0] wr_addr,
    output logic             rd_en,
    output logic [CNT_W-1:0] rd_addr,
    output logic             rd_odd,
    output logic [1:0]       rd_sel,
    output logic             rgb_valid,
    output logic             line_done,
    output logic [2:0]       lines_avail,
    output logic             ovf_err,
    output logic             late_err
);
    typedef enum logic [1:0] {W_IDLE, W_LINE, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_RUN} r_state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_LENGTH - 1);
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic wr_full, line_start, line_end, rd_last;
    logic [1:0] rgb_pipe;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_comb begin
        line_start = (w_state == W_IDLE) & data_valid & ~frame_start;
        line_end = (w_state != W_IDLE) & ~data_valid & ~frame_start;
        wr_en = data_valid & ~rst & ~frame_start & (w_state != W_DROP) & ~wr_full;
        rd_en = r_state == R_RUN;
        rd_last = rd_en & rd_odd & (rd_addr == LAST);
        rgb_valid = rgb_pipe[1];
        w_next = (frame_start | line_end) ? W_IDLE :
                 line_start ? W_LINE :
                 (data_valid & wr_full) ? W_DROP : w_state;
        r_next = (frame_start | rd_last) ? R_IDLE :
                 (line_start & (r_state == R_IDLE) & (lines_avail >= 3'(MIN_LINES))) ? R_RUN : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_full <= 1'b0;
            wr_sel <= '0;
            rd_addr <= '0;
            rd_odd <= 1'b0;
            rd_sel <= '0;
            lines_avail <= '0;
            rgb_pipe <= '0;
            line_done <= 1'b0;
            ovf_err <= 1'b0;
            late_err <= 1'b0;
        end else if (frame_start) begin
            wr_addr <= '0;
            wr_full <= 1'b0;
            wr_sel <= '0;
            rd_addr <= '0;
            rd_odd <= 1'b0;
            rd_sel <= '0;
            lines_avail <= '0;
            rgb_pipe <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= rd_last;
            rgb_pipe <= {rgb_pipe[0], rd_en};
            if (line_end) begin
                wr_addr <= '0;
                wr_full <= 1'b0;
                wr_sel <= wr_sel + 2'd1;
            end else if (wr_en) begin
                if (wr_addr == LAST) wr_full <= 1'b1;
                else wr_addr <= wr_addr + CNT_W'(1);
            end
            if (data_valid & wr_full) ovf_err <= 1'b1;
            if (line_start & rd_en) late_err <= 1'b1;
            if (rd_last) begin
                rd_addr <= '0;
                rd_odd <= 1'b0;
                rd_sel <= rd_sel + 2'd1;
            end else if (rd_en) begin
                rd_odd <= ~rd_odd;
                if (rd_odd) rd_addr <= rd_addr + CNT_W'(1);
            end
            // a line landing in a full ring overwrites the oldest unread line
            if (line_end & ~rd_last) begin
                if (lines_avail == 3'd4) ovf_err <= 1'b1;
                else lines_avail <= lines_avail + 3'd1;
            end else if (rd_last & ~line_end & (lines_avail != 3'd0)) begin
                lines_avail <= lines_avail - 3'd1;
            end
        end
    end
endmodule
